// File: rtl/simon_sequencer_pkg.sv
// simon_sequencer_pkg: shared FSM states, symbol/LED widths and symbol-to-LED decode.
package simon_sequencer_pkg;
    localparam int SYM_W = 2;
    localparam int LED_W = 4;

    typedef enum logic [2:0] {IDLE, APPEND, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE} state_e;

    function automatic logic [LED_W-1:0] onehot(input logic [SYM_W-1:0] sym);
        return LED_W'(1) << sym;
    endfunction
endpackage

// File: rtl/simon_sequencer_phase_timer.sv
// phase_timer: down-counter for the lit and dark playback phases; done_o is high on the last cycle of a phase.
module phase_timer #(
    parameter int SHOW_CYC = 4,
    parameter int GAP_CYC  = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic load_i,
    input  logic gap_i,
    output logic done_o
);
    localparam int CNT_W = $clog2((SHOW_CYC > GAP_CYC ? SHOW_CYC : GAP_CYC) + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb
        cnt_d = load_i ? (gap_i ? CNT_W'(GAP_CYC - 1) : CNT_W'(SHOW_CYC - 1))
                       : (cnt_q != '0 ? cnt_q - CNT_W'(1) : cnt_q);

    always_ff @(posedge clk)
        cnt_q <= !resetn ? '0 : cnt_d;

    assign done_o = cnt_q == '0;
endmodule

// File: rtl/simon_sequencer.sv
// simon_sequencer: grows a random symbol sequence one round at a time, plays it on one-hot LEDs
// and checks the player's presses, reporting win/lose and the current level.
module simon_sequencer
    import simon_sequencer_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int SHOW_CYC = 4,
    parameter int GAP_CYC  = 2,
    parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [SYM_W-1:0] rnd_in,
    output logic             get,
    input  logic             btn_valid,
    input  logic [SYM_W-1:0] btn,
    output logic [LED_W-1:0] led,
    output logic             busy,
    output logic [LEN_W-1:0] level,
    output logic             win,
    output logic             lose
);
    localparam int IDX_W = $clog2(MAX_LEN);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d;
    logic             win_q, win_d, lose_q, lose_d, busy_q;
    logic [SYM_W-1:0] mem_q [MAX_LEN];
    logic             load, gap, done, we, last, full;
    logic [SYM_W-1:0] sym;

    phase_timer #(.SHOW_CYC(SHOW_CYC), .GAP_CYC(GAP_CYC)) u_timer (
        .clk   (clk),
        .resetn(resetn),
        .load_i(load),
        .gap_i (gap),
        .done_o(done)
    );

    assign sym  = mem_q[idx_q[IDX_W-1:0]];
    assign last = idx_q == len_q - LEN_W'(1);
    assign full = len_q == LEN_W'(MAX_LEN);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        win_d   = win_q;
        lose_d  = lose_q;
        load    = 1'b0;
        gap     = 1'b0;
        we      = 1'b0;
        case (state_q)
            IDLE, WIN, LOSE: if (start) begin
                state_d = APPEND;
                len_d   = '0;
                win_d   = 1'b0;
                lose_d  = 1'b0;
            end
            APPEND: begin
                we      = 1'b1;
                len_d   = len_q + LEN_W'(1);
                idx_d   = '0;
                load    = 1'b1;
                state_d = SHOW_ON;
            end
            SHOW_ON: if (done) begin
                load    = 1'b1;
                gap     = 1'b1;
                state_d = SHOW_OFF;
            end
            SHOW_OFF: if (done) begin
                load    = !last;
                idx_d   = last ? '0 : idx_q + LEN_W'(1);
                state_d = last ? WAIT_IN : SHOW_ON;
            end
            WAIT_IN: if (btn_valid) begin
                if (btn != sym) begin
                    state_d = LOSE;
                    lose_d  = 1'b1;
                end else if (!last) idx_d = idx_q + LEN_W'(1);
                else if (full) begin
                    state_d = WIN;
                    win_d   = 1'b1;
                end else state_d = APPEND;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            busy_q  <= !(state_d inside {IDLE, WIN, LOSE});
        end
    end

    // APPEND is only reachable while len < MAX_LEN, so the write never leaves the buffer.
    always_ff @(posedge clk)
        if (we) mem_q[len_q[IDX_W-1:0]] <= rnd_in;

    assign get   = state_q == APPEND;
    assign led   = state_q == SHOW_ON ? onehot(sym) : '0;
    assign busy  = busy_q;
    assign level = len_q;
    assign win   = win_q;
    assign lose  = lose_q;
endmodule

// File: tb/tb_simon_sequencer.sv
// tb_simon_sequencer: directed and randomized games checked every cycle against a
// timeline model of the game (sequence queue plus playback offset arithmetic).
module tb_simon_sequencer;
    localparam int ML = 4, S = 4, G = 2, P = S + G, LW = $clog2(ML + 1);
    localparam int M_IDLE = 0, M_APP = 1, M_PLAY = 2, M_WAIT = 3, M_WIN = 4, M_LOSE = 5;

    logic          clk = 0, resetn = 0, start = 0, btn_valid = 0;
    logic [1:0]    rnd_in = 0, btn = 0;
    logic          get, busy, win, lose;
    logic [3:0]    led;
    logic [LW-1:0] level;

    int         n_tests = 0, n_fail = 0, cyc_n = 0;
    int         m_mode = M_IDLE, m_t = 0, m_pos = 0;
    bit         m_win = 0, m_lose = 0, armed = 0, hold = 1;
    logic [1:0] seq[$];
    int         lit_n = 0, first_lit = 0, last_lit = 0;
    logic [3:0] first_val = 0;
    logic [1:0] pat [4] = '{2'd3, 2'd0, 2'd1, 2'd2};

    always #5 clk = ~clk;

    simon_sequencer #(.MAX_LEN(ML), .SHOW_CYC(S), .GAP_CYC(G)) dut (
        .clk(clk), .resetn(resetn), .start(start), .rnd_in(rnd_in), .get(get),
        .btn_valid(btn_valid), .btn(btn), .led(led), .busy(busy), .level(level),
        .win(win), .lose(lose)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_n);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc_n, act, exp);
        end
    endtask

    // Advance the game model by one clock edge using the inputs the DUT just sampled.
    task automatic model_step();
        if (!resetn) begin
            m_mode = M_IDLE;
            seq.delete();
            m_win  = 0;
            m_lose = 0;
            armed  = 1;
            return;
        end
        case (m_mode)
            M_IDLE, M_WIN, M_LOSE: if (start) begin
                seq.delete();
                m_win  = 0;
                m_lose = 0;
                m_mode = M_APP;
            end
            M_APP: begin
                seq.push_back(rnd_in);
                m_t    = 0;
                m_mode = M_PLAY;
            end
            M_PLAY: begin
                m_t++;
                if (m_t == seq.size() * P) begin
                    m_mode = M_WAIT;
                    m_pos  = 0;
                end
            end
            M_WAIT: if (btn_valid) begin
                if (btn != seq[m_pos]) begin
                    m_lose = 1;
                    m_mode = M_LOSE;
                end else begin
                    m_pos++;
                    if (m_pos == seq.size()) begin
                        if (seq.size() == ML) begin
                            m_win  = 1;
                            m_mode = M_WIN;
                        end else m_mode = M_APP;
                    end
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [3:0] exp_led();
        if (m_mode != M_PLAY || m_t % P >= S) return 4'b0;
        return 4'(1) << seq[m_t / P];
    endfunction

    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        model_step();
        if (armed) begin
            chk("get", get, m_mode == M_APP);
            chk("led", led, exp_led());
            chk("busy", busy, m_mode inside {M_APP, M_PLAY, M_WAIT});
            chk("level", level, seq.size());
            chk("win", win, m_win);
            chk("lose", lose, m_lose);
        end
        if (get === 1'b1) lit_n = 0;
        else if (led != 4'b0) begin
            if (lit_n == 0) begin
                first_lit = cyc_n;
                first_val = led;
            end
            last_lit = cyc_n;
            lit_n++;
        end
        if (!hold) rnd_in = 2'($urandom);
    endtask

    task automatic wait_mode(input int mode, input int budget);
        int n = 0;
        while (m_mode != mode && n < budget) begin
            cyc();
            n++;
        end
        if (m_mode != mode) chk("wait_timeout", m_mode, mode);
    endtask

    task automatic answer_round(input logic [1:0] nxt);
        wait_mode(M_WAIT, 200);
        for (int i = 0; i < seq.size(); i++) begin
            btn_valid = 1;
            btn = seq[i];
            if (i == seq.size() - 1) rnd_in = nxt;
            cyc();
        end
        btn_valid = 0;
    endtask

    task automatic do_reset();
        resetn = 0;
        start = 0;
        btn_valid = 0;
        cyc();
        cyc();
        resetn = 1;
    endtask

    initial begin
        do_reset();
        repeat (20) cyc();
        chk("idle_led", led, 0);
        chk("idle_get", get, 0);
        chk("idle_busy", busy, 0);
        chk("idle_level", level, 0);
        chk("idle_win", win, 0);
        chk("idle_lose", lose, 0);

        rnd_in = 2; start = 1; cyc(); start = 0;
        chk("r1_get", get, 1);
        cyc();
        chk("r1_get_once", get, 0);
        chk("r1_first_led", led, 4'b0100);
        wait_mode(M_WAIT, 100);
        chk("r1_lit_cycles", lit_n, 4);
        chk("r1_led_val", first_val, 4);
        chk("r1_level", level, 1);
        btn_valid = 1; btn = 2; cyc(); btn_valid = 0;
        chk("r1_get_again", get, 1);
        cyc();
        chk("r2_level", level, 2);

        do_reset();
        rnd_in = 3; start = 1; cyc(); start = 0;
        for (int k = 1; k <= 4; k++) begin
            wait_mode(M_WAIT, 200);
            chk("win_lit_cycles", lit_n, 4 * k);
            chk("win_round_span", last_lit - first_lit, P * k - 3);
            answer_round(k < 4 ? pat[k] : 2'd0);
        end
        chk("win_flag", win, 1);
        chk("win_busy", busy, 0);
        chk("win_level", level, 4);

        rnd_in = 3; start = 1; cyc(); start = 0;
        answer_round(0);
        wait_mode(M_PLAY, 10);
        repeat (10) begin
            btn_valid = 1'($urandom); btn = 2'($urandom); start = 1'($urandom);
            cyc();
        end
        btn_valid = 0; start = 0;
        wait_mode(M_WAIT, 100);
        chk("noise_lit_cycles", lit_n, 8);
        chk("noise_span", last_lit - first_lit, 9);
        chk("noise_level", level, 2);
        answer_round(1);
        wait_mode(M_WAIT, 100);
        btn_valid = 1; btn = 3; cyc();
        btn = 2; cyc(); btn_valid = 0;
        chk("lose_flag", lose, 1);
        chk("lose_busy", busy, 0);
        chk("lose_get", get, 0);
        chk("lose_level", level, 3);
        cyc();
        chk("lose_no_get", get, 0);

        rnd_in = 1; start = 1; cyc(); start = 0;
        answer_round(2);
        cyc();
        chk("pre_reset_led", led, 4'b0010);
        resetn = 0; cyc();
        chk("rst_led", led, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        resetn = 1;
        start = 1; cyc(); start = 0; cyc();
        chk("restart_level", level, 1);

        hold = 0;
        for (int g = 0; g < 8; g++) begin
            bit bad;
            int bad_round, n;
            bad = ($urandom % 3 == 0);
            bad_round = 1 + int'($urandom % ML);
            n = 0;
            start = 1; cyc(); start = 0;
            while (!(m_mode inside {M_WIN, M_LOSE}) && n < 2000) begin
                if (m_mode == M_WAIT) begin
                    btn_valid = ($urandom % 3 != 0);
                    btn = (bad && seq.size() == bad_round && m_pos == seq.size() - 1) ? ~seq[m_pos] : seq[m_pos];
                    start = ($urandom % 6 == 0);
                end else begin
                    btn_valid = ($urandom % 8 == 0);
                    btn = 2'($urandom);
                    start = ($urandom % 8 == 0);
                end
                cyc();
                n++;
            end
            btn_valid = 0; start = 0;
            if (n >= 2000) chk("game_timeout", n, 0);
            chk("game_outcome", win ? 1 : lose ? 2 : 0, bad ? 2 : 1);
            repeat (3) cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/simon_sequencer.md
Name: simon_sequencer

Overview:
Game-sequence engine that consumes the 2-bit pseudo-random symbols from the LFSR stage. It requests one symbol per round with a single-cycle `get` strobe and appends it to an on-chip sequence buffer. It plays the whole sequence back on four one-hot LEDs with programmable on/gap timing, then checks the player's button presses. It reports `win` or `lose` and the current level to the display/top-level controller.

Parameters:
MAX_LEN, 16, sequence length needed to win (2..64)
SHOW_CYC, 4, clk cycles each LED stays lit during playback (>=1)
GAP_CYC, 2, clk cycles of dark gap after each lit LED (>=1)
LEN_W, $clog2(MAX_LEN+1), width of length/level counters

Ports:
clk  input  1  clock
resetn  input  1  reset, synchronous, active-low
start  input  1  one-cycle pulse: begin a new game
rnd_in  input  2  random symbol from the LFSR, valid combinationally every cycle
get  output  1  one-cycle request to the LFSR to advance
btn_valid  input  1  one-cycle pulse: player pressed a button
btn  input  2  encoded button index, sampled when btn_valid=1
led  output  4  one-hot playback display, led[k] lit for symbol k
busy  output  1  high in any state except IDLE/WIN/LOSE
level  output  LEN_W  current sequence length
win  output  1  sticky: MAX_LEN rounds completed
lose  output  1  sticky: wrong button pressed

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE; len, idx and timer cleared; get=0, led=0, busy=0, level=0, win=0, lose=0. Buffer contents are don't-care. Reset mid-game aborts the game on that edge with no residual get pulse.
- All outputs are registered, except `get` and `led`, which are decoded from registered state only.
- IDLE: waits. A start pulse clears len and win/lose, then goes to APPEND.
- APPEND (exactly 1 cycle):
  - get=1.
  - At the same edge: mem[len] <= rnd_in (the pre-shift value), len <= len+1, idx <= 0.
  - Next state is SHOW_ON.
- SHOW_ON: led = onehot(mem[idx]) for exactly SHOW_CYC cycles, then SHOW_OFF.
- SHOW_OFF: led=0 for exactly GAP_CYC cycles.
  - If idx==len-1: idx <= 0, go to WAIT_IN.
  - Otherwise: idx <= idx+1, go to SHOW_ON.
- WAIT_IN: led=0. On a btn_valid cycle:
  - btn != mem[idx]: go to LOSE.
  - btn == mem[idx] and idx < len-1: idx <= idx+1.
  - btn == mem[idx], idx == len-1 and len == MAX_LEN: go to WIN.
  - btn == mem[idx], idx == len-1 and len < MAX_LEN: go to APPEND (next round).
- WIN / LOSE: the matching flag is held high and busy=0. A start pulse begins a new game exactly as from IDLE.
- Ignored inputs:
  - start is ignored while busy=1.
  - btn_valid is ignored outside WAIT_IN, including during playback.
- Simultaneous events: resetn=0 dominates everything. Within WAIT_IN, start and btn_valid arriving together means btn_valid is processed and start is ignored.
- Latency:
  - start at edge N: get high in cycle N+1; first LED lit in cycles N+2 .. N+1+SHOW_CYC.
  - Final correct button at edge M: get high in cycle M+1.
- Round timing: one round of playback lasts len*(SHOW_CYC+GAP_CYC) cycles.
- level == len at all times; it saturates at MAX_LEN and never wraps.
- Width: idx and len use LEN_W bits. The buffer is MAX_LEN x 2 bits, with no write beyond MAX_LEN-1.

Decomposition:
- Shared package holds:
  - state enum (IDLE, APPEND, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE);
  - SYM_W=2 and LED_W=4 constants;
  - a onehot-decode function.
- Sub-module phase_timer: down-counter loaded with SHOW_CYC-1 or GAP_CYC-1, with a `done` output. It is reused for both playback phases.
- Buffer is an inferred register array inside simon_sequencer.

Test Plan:
- Reset then idle: no start for 20 cycles -> led=0, get=0, busy=0, level=0, win=lose=0.
- Single round: MAX_LEN=4, rnd_in=2'b10, pulse start.
  - get=1 for exactly 1 cycle.
  - led=4'b0100 for 4 cycles, then 0 for 2.
  - level=1; bench presses btn=2 -> get pulses again, level=2.
- Full win: MAX_LEN=4, bench drives rnd_in sequence 3,0,1,2 and answers every round correctly.
  - Round k playback is exactly k*6 cycles long.
  - After the 4th correct press: win=1, busy=0, level=4.
- Lose mid-sequence: round 3 with stored 3,0,1; bench presses 3 then 2 -> lose=1 on the next cycle, busy=0, no get pulse.
- Ignored inputs: btn_valid during playback and start while busy -> no change in idx, led timing or level.
- Reset mid-playback: resetn=0 during SHOW_ON of round 2 -> next cycle led=0, level=0, state IDLE. A subsequent start restarts at level 1.
